// File: rtl/aes_pkg.sv
// Shared AES types and constants for the round controller and its environment.
package aes_pkg;

    typedef logic [127:0] aes_block_t;

    localparam int AES_NR = 10;

    typedef enum logic [2:0] {
        IDLE,
        KEY_WAIT,
        ARK,
        SB,
        SR,
        MC,
        DONE
    } aes_ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: owns the state register, fires one stage enable per cycle, fetches round keys.
// Optional abort input is compiled in when AES_ROUND_CTRL_ABORT_EN is defined.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              key_req,
    output logic [3:0]        key_round,
    input  logic              key_valid,
    output logic [DATA_W-1:0] state_out,
    output logic              ark_enable,
    output logic              sb_enable,
    output logic              sr_enable,
    output logic              mc_enable,
    input  logic [DATA_W-1:0] ark_out,
    input  logic [DATA_W-1:0] sb_out,
    input  logic [DATA_W-1:0] sr_out,
    input  logic [DATA_W-1:0] mc_out
);

    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    aes_ctrl_state_t   fsm_q, fsm_d;
    logic [RW-1:0]     round_q, round_d;
    logic [DATA_W-1:0] blk_q, blk_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            blk_q   <= '0;
            dout_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        round_d    = round_q;
        blk_d      = blk_q;
        dout_d     = dout_q;
        key_req    = 1'b0;
        ark_enable = 1'b0;
        sb_enable  = 1'b0;
        sr_enable  = 1'b0;
        mc_enable  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    blk_d   = data_in;
                    round_d = '0;
                    fsm_d   = KEY_WAIT;
                end
            end
            KEY_WAIT: begin
                key_req = 1'b1;
                if (key_valid) begin
                    fsm_d = ARK;
                end
            end
            ARK: begin
                ark_enable = 1'b1;
                blk_d      = ark_out;
                if (round_q == LAST_ROUND) begin
                    // Ciphertext is latched on entry to DONE so it is valid alongside the done pulse.
                    dout_d = ark_out;
                    fsm_d  = DONE;
                end else begin
                    round_d = round_q + 1'b1;
                    fsm_d   = SB;
                end
            end
            SB: begin
                sb_enable = 1'b1;
                blk_d     = sb_out;
                fsm_d     = SR;
            end
            SR: begin
                sr_enable = 1'b1;
                blk_d     = sr_out;
                fsm_d     = (round_q == LAST_ROUND) ? KEY_WAIT : MC;
            end
            MC: begin
                mc_enable = 1'b1;
                blk_d     = mc_out;
                fsm_d     = KEY_WAIT;
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
        // Abort overrides every transition above and leaves the last ciphertext untouched.
        if (abort && fsm_q != IDLE) begin
            fsm_d   = IDLE;
            round_d = '0;
            blk_d   = blk_q;
            dout_d  = dout_q;
        end
`endif
    end

    assign busy      = (fsm_q != IDLE);
    assign done      = (fsm_q == DONE);
    assign key_round = 4'(round_q);
    assign state_out = blk_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: behavioural AES stages, scoreboard on done, enable/key-order tracking.
module tb_aes_round_ctrl;

    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk, rst, start, key_valid;
    logic [127:0] data_in, data_out, state_out;
    logic [127:0] ark_out, sb_out, sr_out, mc_out;
    logic         busy, done, key_req;
    logic [3:0]   key_round;
    logic         ark_enable, sb_enable, sr_enable, mc_enable;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic         abort;
`endif

    logic [127:0] rk [0:10];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic         stall_en = 1'b0;
    int           stall_cnt = 0;

    logic [127:0] ct_q[$];
    int           lat_q[$];
    logic [3:0]   tr_q[$];
    logic [3:0]   kr_q[$];

    aes_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .key_req    (key_req),
        .key_round  (key_round),
        .key_valid  (key_valid),
        .state_out  (state_out),
        .ark_enable (ark_enable),
        .sb_enable  (sb_enable),
        .sr_enable  (sr_enable),
        .mc_enable  (mc_enable),
        .ark_out    (ark_out),
        .sb_out     (sb_out),
        .sr_out     (sr_out),
        .mc_out     (mc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int n);
        logic [15:0] t = {b, b};
        return t[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] t = a;
        // a^254 is the multiplicative inverse; zero maps to zero.
        for (int i = 0; i < 7; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        if (a == 8'h00) r = 8'h00;
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] gb(logic [127:0] s, int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] f_sb(logic [127:0] s);
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(gb(s, i));
        return o;
    endfunction

    function automatic logic [127:0] f_sr(logic [127:0] s);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c + r) % 4));
        return o;
    endfunction

    function automatic logic [127:0] f_mc(logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_ref(logic [127:0] pt);
        logic [127:0] s = pt ^ rk[0];
        for (int r = 1; r < 10; r++) s = f_mc(f_sr(f_sb(s))) ^ rk[r];
        return f_sr(f_sb(s)) ^ rk[10];
    endfunction

    assign ark_out = state_out ^ rk[key_round];
    assign sb_out  = f_sb(state_out);
    assign sr_out  = f_sr(state_out);
    assign mc_out  = f_mc(state_out);

    // ---------------- checking ----------------
    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic flush();
        ct_q.delete(); lat_q.delete(); tr_q.delete(); kr_q.delete();
    endtask

    // Monitor: runs on negedges, counts cycles since the accepting edge.
    initial begin
        logic       acc_pending = 1'b0;
        logic       prev_kreq   = 1'b0;
        int         cyc = 0;
        logic [3:0] en;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_pending = 1'b0;
                prev_kreq   = 1'b0;
                cyc         = 0;
                flush();
            end else begin
                cyc = acc_pending ? 1 : cyc + 1;
                en  = {ark_enable, sb_enable, sr_enable, mc_enable};
                check("onehot", ($countones(en) <= 1) && !(key_req && (|en)), 1);
                if (|en) begin
                    if (tr_q.size() == 0) check("en_extra", en, 0);
                    else check("en_order", en, tr_q.pop_front());
                end
                if (key_req && !prev_kreq) begin
                    if (kr_q.size() == 0) check("kreq_extra", 1, 0);
                    else check("key_round", key_round, kr_q.pop_front());
                end
                prev_kreq = key_req;
                if (done) begin
                    if (ct_q.size() == 0) begin
                        check("spurious_done", 1, 0);
                    end else begin
                        check("data_out", data_out, ct_q.pop_front());
                        check("latency", cyc, lat_q.pop_front());
                    end
                end
                acc_pending = start && !busy;
                if (acc_pending) begin
                    ct_q.push_back(aes_ref(data_in));
                    lat_q.push_back(stall_en ? 55 : 52);
                    tr_q.push_back(4'b1000);
                    for (int r = 0; r < 9; r++) begin
                        tr_q.push_back(4'b0100); tr_q.push_back(4'b0010);
                        tr_q.push_back(4'b0001); tr_q.push_back(4'b1000);
                    end
                    tr_q.push_back(4'b0100); tr_q.push_back(4'b0010); tr_q.push_back(4'b1000);
                    for (int k = 0; k <= 10; k++) kr_q.push_back(4'(k));
                end
            end
        end
    end

    // Key scheduler stand-in: withholds key 5 for three cycles when stalling is enabled.
    initial begin
        key_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (!stall_en) stall_cnt = 0;
            if (stall_en && key_req && key_round == 4'd5 && stall_cnt < 3) begin
                key_valid = 1'b0;
                stall_cnt++;
            end else begin
                key_valid = 1'b1;
            end
        end
    end

    task automatic start_op(logic [127:0] pt);
        @(posedge clk); #2;
        data_in = pt;
        start   = 1'b1;
        @(posedge clk); #2;
        start   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_dout"}, data_out, 0);
        check({tag, "_kreq"}, key_req, 0);
        check({tag, "_kround"}, key_round, 0);
        check({tag, "_state"}, state_out, 0);
        check({tag, "_en"}, {ark_enable, sb_enable, sr_enable, mc_enable}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] w [0:43];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] pt2, pt3;

        rst = 1'b1; start = 1'b0; data_in = '0;
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 4; i++) w[i] = {96'h0, KEY[127-32*i -: 32]};
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1][31:0];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = {96'h0, w[i-4][31:0] ^ t};
        end
        for (int k = 0; k <= 10; k++)
            rk[k] = {w[4*k][31:0], w[4*k+1][31:0], w[4*k+2][31:0], w[4*k+3][31:0]};

        check("ref_fips", aes_ref(FIPS_PT), FIPS_CT);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // FIPS-197 C.1 vector with key always available
        start_op(FIPS_PT);
        wait_done();
        check("fips_ct", data_out, FIPS_CT);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("dout_hold", data_out, FIPS_CT);

        // Key 5 withheld for three cycles
        stall_en = 1'b1;
        start_op(FIPS_PT);
        wait_done();
        check("stall_ct", data_out, FIPS_CT);
        stall_en = 1'b0;

        // Start while busy is ignored; a later start runs normally
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        pt3 = {$urandom, $urandom, $urandom, $urandom};
        start_op(pt2);
        repeat (19) @(posedge clk);
        #2; data_in = pt3; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        wait_done();
        check("ignored_start_ct", data_out, aes_ref(pt2));
        repeat (10) @(posedge clk);
        check("no_second_op", busy, 0);
        start_op(pt3);
        wait_done();
        check("second_ct", data_out, aes_ref(pt3));

        // Asynchronous reset mid-operation
        start_op(pt2);
        repeat (29) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        flush();
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        check("post_rst_busy", busy, 0);
        start_op(FIPS_PT);
        wait_done();
        check("post_rst_ct", data_out, FIPS_CT);

`ifdef AES_ROUND_CTRL_ABORT_EN
        // Abort returns to IDLE without touching the last ciphertext
        start_op(pt3);
        repeat (9) @(posedge clk);
        #2; abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        flush();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dout", data_out, FIPS_CT);
        check("abort_kround", key_round, 0);
        repeat (60) @(posedge clk);
        #2;
        check("abort_idle", busy, 0);
        check("abort_dout_hold", data_out, FIPS_CT);
`endif

        repeat (5) @(posedge clk);
        #2;
        check("sb_empty", ct_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
